// File: rtl/spi_pkg.sv
// Shared SPI byte-transmitter definitions: byte width, clock polarity and FSM states.
package spi_pkg;

  localparam int unsigned SPI_BYTE_W = 8;
  localparam logic        CPOL       = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period counter for sclk generation; emits a one-cycle tick every DIV_HALF clocks.
module spi_clk_div #(
  parameter int unsigned DIV_HALF = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned     CW   = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam logic [CW-1:0]   LAST = CW'(DIV_HALF - 1);

  logic [CW-1:0] div_cnt;

  assign tick = !clear && (div_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_byte_tx.sv
// SPI mode-0 transmit-only byte shifter, MSB first, with one-cycle completion strobe.
module spi_byte_tx
  import spi_pkg::*;
#(
  parameter int unsigned DIV_HALF = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [SPI_BYTE_W-1:0] dat,
  output logic                  sclk,
  output logic                  sdo,
  output logic                  snt,
  output logic                  busy
);

  spi_state_e            state, state_n;
  logic [SPI_BYTE_W-1:0] shreg, shreg_n;
  logic [2:0]            bit_cnt, bit_cnt_n;
  logic                  sclk_n, sdo_n, snt_n, busy_n;
  logic                  tick;

  spi_clk_div #(
    .DIV_HALF(DIV_HALF)
  ) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(state == ST_IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      sclk    <= CPOL;
      sdo     <= 1'b0;
      snt     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_cnt <= bit_cnt_n;
      sclk    <= sclk_n;
      sdo     <= sdo_n;
      snt     <= snt_n;
      busy    <= busy_n;
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    sclk_n    = sclk;
    sdo_n     = sdo;
    snt_n     = 1'b0;
    busy_n    = busy;
    case (state)
      ST_IDLE: begin
        sclk_n = CPOL;
        sdo_n  = 1'b0;
        busy_n = 1'b0;
        if (req) begin
          state_n   = ST_LOW;
          shreg_n   = dat;
          sdo_n     = dat[SPI_BYTE_W-1];
          busy_n    = 1'b1;
          bit_cnt_n = '0;
        end
      end
      ST_LOW: begin
        if (tick) begin
          sclk_n  = ~CPOL;
          state_n = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (tick) begin
          sclk_n = CPOL;
          // sdo only moves on the falling edge, giving a full half-period of setup before the next rise
          if (bit_cnt != 3'(SPI_BYTE_W - 1)) begin
            shreg_n   = shreg << 1;
            sdo_n     = shreg_n[SPI_BYTE_W-1];
            bit_cnt_n = bit_cnt + 3'd1;
            state_n   = ST_LOW;
          end else begin
            sdo_n   = 1'b0;
            snt_n   = 1'b1;
            busy_n  = 1'b0;
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_byte_tx.sv
// Directed bench for spi_byte_tx at DIV_HALF=4 and DIV_HALF=1 with a cycle-indexed expectation model.
module tb_spi_byte_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic [7:0] dat;
  logic       sel;
  logic       req4, req1;
  logic       sclk4, sdo4, snt4, busy4;
  logic       sclk1, sdo1, snt1, busy1;
  logic       osclk, osdo, osnt, obusy;
  int         checks = 0;
  int         errors = 0;
  int         snt_cnt4 = 0;
  int         snt_base;

  always #5 clk = ~clk;

  assign req4  = req & ~sel;
  assign req1  = req & sel;
  assign osclk = sel ? sclk1 : sclk4;
  assign osdo  = sel ? sdo1  : sdo4;
  assign osnt  = sel ? snt1  : snt4;
  assign obusy = sel ? busy1 : busy4;

  spi_byte_tx #(.DIV_HALF(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .dat(dat),
    .sclk(sclk4), .sdo(sdo4), .snt(snt4), .busy(busy4)
  );

  spi_byte_tx #(.DIV_HALF(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .dat(dat),
    .sclk(sclk1), .sdo(sdo1), .snt(snt1), .busy(busy1)
  );

  always @(negedge clk) if (snt4 === 1'b1) snt_cnt4++;

  task automatic chk(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk(tag, i, {28'd0, osclk, osdo, obusy, osnt}, 32'd0);
    end
  endtask

  // Caller sits at a negedge; sample n is taken at the negedge after edge E0+n.
  task automatic xfer(input string tag, input int d, input logic [7:0] b, input bit hold,
                      input logic [7:0] nextb, input int poke_n, input logic [7:0] poke_b,
                      input int abort_n);
    logic [7:0] dec;
    logic [3:0] exp;
    dec = 8'h00;
    req = 1'b1;
    dat = b;
    for (int n = 0; n <= 16*d; n++) begin
      @(negedge clk);
      if (n == 0 && !hold) req = 1'b0;
      if (n == poke_n) begin req = 1'b1; dat = poke_b; end
      if (n == poke_n + 1) begin req = 1'b0; dat = b; end
      if (n < 16*d) exp = {((n/d)%2) == 1, b[7 - n/(2*d)], 1'b1, 1'b0};
      else          exp = 4'b0001;
      chk(tag, n, {28'd0, osclk, osdo, obusy, osnt}, {28'd0, exp});
      if (n % (2*d) == d) dec = {dec[6:0], osdo};
      if (hold && n == 16*d) dat = nextb;
      if (n == abort_n) begin
        rst_n = 1'b0;
        break;
      end
    end
    if (abort_n < 0) chk({tag, "_decoded"}, 0, {24'd0, dec}, {24'd0, b});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    dat   = 8'h00;
    sel   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset4", 0, {28'd0, sclk4, sdo4, busy4, snt4}, 32'd0);
    chk("reset1", 0, {28'd0, sclk1, sdo1, busy1, snt1}, 32'd0);
    rst_n = 1'b1;

    // 1: idle after reset
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle4", i, {28'd0, sclk4, sdo4, busy4, snt4}, 32'd0);
      chk("idle1", i, {28'd0, sclk1, sdo1, busy1, snt1}, 32'd0);
    end

    // 2: single byte
    snt_base = snt_cnt4;
    xfer("a5", 4, 8'hA5, 1'b0, 8'h00, -1, 8'h00, -1);
    idle_chk("a5_after", 5);
    chk("a5_snt_count", 0, snt_cnt4 - snt_base, 1);

    // 3: back-to-back with req held high
    snt_base = snt_cnt4;
    xfer("b2b_00", 4, 8'h00, 1'b1, 8'hFF, -1, 8'h00, -1);
    xfer("b2b_ff", 4, 8'hFF, 1'b0, 8'h00, -1, 8'h00, -1);
    idle_chk("b2b_after", 5);
    chk("b2b_snt_count", 0, snt_cnt4 - snt_base, 2);

    // 4: request while busy is dropped
    snt_base = snt_cnt4;
    xfer("busy_3c", 4, 8'h3C, 1'b0, 8'h00, 20, 8'hC3, -1);
    idle_chk("busy_after", 40);
    chk("busy_snt_count", 0, snt_cnt4 - snt_base, 1);

    // 5: reset after the third sclk rise
    snt_base = snt_cnt4;
    xfer("abort", 4, 8'h5A, 1'b0, 8'h00, -1, 8'h00, 20);
    @(negedge clk);
    chk("abort_reset", 0, {28'd0, osclk, osdo, obusy, osnt}, 32'd0);
    rst_n = 1'b1;
    idle_chk("abort_idle", 20);
    chk("abort_snt_count", 0, snt_cnt4 - snt_base, 0);
    xfer("post_abort_81", 4, 8'h81, 1'b0, 8'h00, -1, 8'h00, -1);
    idle_chk("post_abort_after", 3);

    // 6: fastest divider
    sel = 1'b1;
    @(negedge clk);
    xfer("d1_81", 1, 8'h81, 1'b0, 8'h00, -1, 8'h00, -1);
    idle_chk("d1_after", 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
